// File: rtl/arith_unit_arbiter_pkg.sv
// Shared types and op-code helpers for the arithmetic-unit arbiter.
// Holds the FSM state encoding and the legal-op check used at capture time.
package arith_unit_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] ARITH_OP_ADD = 2'b00;
    localparam logic [1:0] ARITH_OP_SUB = 2'b01;

    function automatic logic op_legal(input logic [1:0] op);
        return (op == ARITH_OP_ADD) || (op == ARITH_OP_SUB);
    endfunction

endpackage

// File: rtl/arith_unit_arbiter_rr_select.sv
// Combinational round-robin selector: first asserted request at or after ptr_i
// (wrapping modulo N) wins; grant is one-hot or all-zero.
module rr_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o
);

    always_comb begin
        logic        found;
        int unsigned idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_i) + i) % N;
            if (!found && req_i[PTR_W'(idx)]) begin
                grant_o[PTR_W'(idx)] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arith_unit_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub unit between NUM_REQ
// requesters; fixed two-cycle accept-to-response latency, one op in flight.
module arith_unit_arbiter
    import arith_unit_arbiter_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned NUM_REQ       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [2*NUM_REQ-1:0]             req_op,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_lhs,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_rhs,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [OPERAND_WIDTH-1:0]         rsp_result,
    output logic                             rsp_error,
    output logic [1:0]                       au_operation,
    output logic [OPERAND_WIDTH-1:0]         au_lhs,
    output logic [OPERAND_WIDTH-1:0]         au_rhs,
    input  logic [OPERAND_WIDTH-1:0]         au_result
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned W     = OPERAND_WIDTH;

    state_e               state_q;
    logic                 armed_q;
    logic [IDX_W-1:0]     last_grant_q;
    logic [1:0]           op_q;
    logic [W-1:0]         lhs_q;
    logic [W-1:0]         rhs_q;
    logic [W-1:0]         result_q;
    logic                 error_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;

    logic [IDX_W-1:0]     rr_start;
    logic [NUM_REQ-1:0]   rr_grant;
    logic [IDX_W-1:0]     sel_idx;
    logic [1:0]           sel_op;
    logic [W-1:0]         sel_lhs;
    logic [W-1:0]         sel_rhs;
    logic                 accept;
    logic                 rsp_done;

    assign rr_start = IDX_W'((32'(last_grant_q) + 32'd1) % NUM_REQ);

    rr_select #(
        .N     (NUM_REQ),
        .PTR_W (IDX_W)
    ) u_rr_select (
        .req_i   (req_valid),
        .ptr_i   (rr_start),
        .grant_o (rr_grant)
    );

    // armed_q keeps the release edge from accepting anything
    assign req_ready = (state_q == ST_IDLE && armed_q) ? rr_grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign rsp_done  = |(rsp_valid_q & rsp_ready);

    always_comb begin
        sel_idx = '0;
        sel_op  = '0;
        sel_lhs = '0;
        sel_rhs = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rr_grant[i]) begin
                sel_idx = IDX_W'(i);
                sel_op  = req_op[2*i +: 2];
                sel_lhs = req_lhs[W*i +: W];
                sel_rhs = req_rhs[W*i +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            op_q         <= '0;
            lhs_q        <= '0;
            rhs_q        <= '0;
            result_q     <= '0;
            error_q      <= 1'b0;
            rsp_valid_q  <= '0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q         <= sel_op;
                        lhs_q        <= sel_lhs;
                        rhs_q        <= sel_rhs;
                        last_grant_q <= sel_idx;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // illegal ops still take the same path so latency stays fixed
                    if (op_legal(op_q)) begin
                        result_q <= au_result;
                        error_q  <= 1'b0;
                    end else begin
                        result_q <= '0;
                        error_q  <= 1'b1;
                    end
                    rsp_valid_q <= NUM_REQ'(1) << last_grant_q;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_done) begin
                        rsp_valid_q <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = result_q;
    assign rsp_error    = error_q;
    assign au_operation = op_q;
    assign au_lhs       = lhs_q;
    assign au_rhs       = rhs_q;

endmodule

// File: tb/tb_arith_unit_arbiter.sv
// Bench for arith_unit_arbiter: random traffic checked against a round-robin /
// modular-arithmetic reference model, plus directed latency and reset cases.
module tb_arith_unit_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2*N-1:0]   req_op;
    logic [N*W-1:0]   req_lhs, req_rhs;
    logic [W-1:0]     rsp_result, au_lhs, au_rhs, au_result;
    logic             rsp_error;
    logic [1:0]       au_operation;

    int n_cmp = 0;
    int n_err = 0;
    int exp_last;

    always #5 clk = ~clk;

    // external arithmetic unit; illegal codes give junk so a missed zeroing shows
    always_comb begin
        case (au_operation)
            2'b00:   au_result = W'(au_lhs + au_rhs);
            2'b01:   au_result = W'(au_lhs - au_rhs);
            default: au_result = au_lhs ^ au_rhs ^ 8'hA5;
        endcase
    end

    arith_unit_arbiter #(.OPERAND_WIDTH(W), .NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_lhs      (req_lhs),
        .req_rhs      (req_rhs),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_error    (rsp_error),
        .au_operation (au_operation),
        .au_lhs       (au_lhs),
        .au_rhs       (au_rhs),
        .au_result    (au_result)
    );

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input int a, input int b);
        if (op == 2'b00) return W'((a + b) % 256);
        if (op == 2'b01) return W'((a - b + 256) % 256);
        return '0;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '1; rsp_ready = '0; req_op = '0;
        req_lhs = '0; req_rhs = '0;
        req_lhs[W-1:0] = 8'd5;
        #3;
        n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid); end
        n_cmp++; if (rsp_result !== '0 || rsp_error !== 1'b0) begin n_err++; $display("FAIL reset_rsp got=%h/%b want=00/0", rsp_result, rsp_error); end
        n_cmp++; if (au_lhs !== '0 || au_rhs !== '0 || au_operation !== '0) begin n_err++; $display("FAIL reset_au got=%h/%h/%b want=0", au_lhs, au_rhs, au_operation); end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
        n_cmp++; if (au_lhs !== '0) begin n_err++; $display("FAIL release_no_accept au_lhs got=%h want=00", au_lhs); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL release_first_prio got=%b want=0001", req_ready); end
        req_valid = '0;
        exp_last = N - 1;
        tick();
    endtask

    task automatic test_single_op(input int idx, input logic [1:0] op, input int a, input int b, input string name);
        int w;
        req_op[2*idx +: 2] = op;
        req_lhs[W*idx +: W] = W'(a);
        req_rhs[W*idx +: W] = W'(b);
        req_valid = onehot(idx);
        #1;
        w = rr_pick(req_valid, exp_last);
        n_cmp++; if (req_ready !== onehot(w)) begin n_err++; $display("FAIL %s_ready got=%b want=%b", name, req_ready, onehot(w)); end
        exp_last = w;
        tick();
        req_valid = '0;
        n_cmp++; if (rsp_valid !== '0 || au_operation !== op || au_lhs !== W'(a)) begin n_err++;
            $display("FAIL %s_exec got=%b/%b/%h want=0000/%b/%h", name, rsp_valid, au_operation, au_lhs, op, W'(a)); end
        tick();
        n_cmp++; if (rsp_valid !== onehot(w) || rsp_result !== ref_result(op, a, b) || rsp_error !== (op > 2'b01)) begin n_err++;
            $display("FAIL %s_rsp got=%b/%h/%b want=%b/%h/%b", name, rsp_valid, rsp_result, rsp_error, onehot(w), ref_result(op, a, b), op > 2'b01); end
        rsp_ready = onehot(w);
        tick();
        rsp_ready = '0;
        n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL %s_done got=%b want=0000", name, rsp_valid); end
    endtask

    task automatic test_round_robin(input int n_ops);
        int w;
        logic [1:0] op;
        int a, b;
        req_valid = '1;
        rsp_ready = '1;
        for (int k = 0; k < n_ops; k++) begin
            for (int i = 0; i < N; i++) begin
                req_op[2*i +: 2] = 2'($urandom_range(0, 1));
                req_lhs[W*i +: W] = W'($urandom);
                req_rhs[W*i +: W] = W'($urandom);
            end
            #1;
            w = rr_pick(req_valid, exp_last);
            op = req_op[2*w +: 2];
            a = int'(req_lhs[W*w +: W]);
            b = int'(req_rhs[W*w +: W]);
            n_cmp++; if (req_ready !== onehot(w)) begin n_err++; $display("FAIL rr_grant op=%0d got=%b want=%b", k, req_ready, onehot(w)); end
            exp_last = w;
            tick();
            tick();
            n_cmp++; if (rsp_valid !== onehot(w) || rsp_result !== ref_result(op, a, b)) begin n_err++;
                $display("FAIL rr_rsp op=%0d got=%b/%h want=%b/%h", k, rsp_valid, rsp_result, onehot(w), ref_result(op, a, b)); end
            tick();
        end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_r;
        int a, b;
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        req_op[7:6] = 2'b00;
        req_lhs[3*W +: W] = W'(a);
        req_rhs[3*W +: W] = W'(b);
        req_valid = 4'b1000;
        exp_r = ref_result(2'b00, a, b);
        tick();
        exp_last = 3;
        req_valid = '1;
        tick();
        for (int c = 0; c < 5; c++) begin
            rsp_ready = 4'b0111;
            tick();
            n_cmp++; if (rsp_valid !== 4'b1000 || rsp_result !== exp_r || req_ready !== '0) begin n_err++;
                $display("FAIL hold cyc=%0d got=%b/%h/%b want=1000/%h/0000", c, rsp_valid, rsp_result, req_ready, exp_r); end
        end
        rsp_ready = 4'b1000;
        tick();
        req_valid = '0;
        rsp_ready = '0;
        n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL hold_release got=%b want=0000", rsp_valid); end
    endtask

    task automatic test_random(input int n_ops);
        int w, d, a, b;
        logic [1:0] op;
        logic [W-1:0] exp_r;
        for (int k = 0; k < n_ops; k++) begin
            for (int i = 0; i < N; i++) begin
                req_op[2*i +: 2] = 2'($urandom);
                req_lhs[W*i +: W] = W'($urandom);
                req_rhs[W*i +: W] = W'($urandom);
            end
            req_valid = 4'($urandom_range(1, 15));
            #1;
            w = rr_pick(req_valid, exp_last);
            op = req_op[2*w +: 2];
            a = int'(req_lhs[W*w +: W]);
            b = int'(req_rhs[W*w +: W]);
            exp_r = ref_result(op, a, b);
            n_cmp++; if (req_ready !== onehot(w)) begin n_err++; $display("FAIL rnd_grant op=%0d got=%b want=%b", k, req_ready, onehot(w)); end
            exp_last = w;
            tick();
            req_valid = 4'($urandom);
            #1;
            n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL rnd_busy op=%0d got=%b want=0000", k, req_ready); end
            tick();
            n_cmp++; if (rsp_valid !== onehot(w) || rsp_result !== exp_r || rsp_error !== (op > 2'b01)) begin n_err++;
                $display("FAIL rnd_rsp op=%0d got=%b/%h/%b want=%b/%h/%b", k, rsp_valid, rsp_result, rsp_error, onehot(w), exp_r, op > 2'b01); end
            d = int'($urandom_range(0, 3));
            for (int c = 0; c < d; c++) begin
                rsp_ready = 4'($urandom) & ~onehot(w);
                tick();
                n_cmp++; if (rsp_valid !== onehot(w) || rsp_result !== exp_r) begin n_err++;
                    $display("FAIL rnd_stall op=%0d got=%b/%h want=%b/%h", k, rsp_valid, rsp_result, onehot(w), exp_r); end
            end
            rsp_ready = 4'($urandom) | onehot(w);
            tick();
            rsp_ready = '0;
            req_valid = '0;
            n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL rnd_done op=%0d got=%b want=0000", k, rsp_valid); end
        end
    endtask

    task automatic test_reset_mid_exec();
        req_op[3:2] = 2'b01;
        req_lhs[W +: W] = 8'd9;
        req_rhs[W +: W] = 8'd4;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== '0 || rsp_result !== '0 || rsp_error !== 1'b0 || au_lhs !== '0 || au_operation !== '0) begin n_err++;
            $display("FAIL midreset_outputs got=%b/%h/%b/%h/%b want=0", rsp_valid, rsp_result, rsp_error, au_lhs, au_operation); end
        tick();
        #2 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL midreset_no_rsp cyc=%0d got=%b want=0000", c, rsp_valid); end
        end
        exp_last = N - 1;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0; rsp_ready = '0; req_op = '0; req_lhs = '0; req_rhs = '0;
        exp_last = N - 1;
        test_reset();
        test_single_op(0, 2'b00, 5, 7, "add_5_7");
        test_single_op(1, 2'b01, 3, 5, "sub_wrap");
        test_single_op(2, 2'b11, 20, 30, "illegal");
        test_round_robin(12);
        test_backpressure();
        test_random(40);
        test_reset_mid_exec();
        test_round_robin(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
